// File: rtl/pe_conv_row_unit.sv
// One PE of a 1-D convolution systolic row: 3-tap delay line, three pipelined
// unsigned multipliers and a registered partial-sum adder. Weights and tap0 go downstream.
module pe_conv_row_unit #(
  parameter int IFMAP_W = 8,
  parameter int WGT_W   = 4,
  parameter int PSUM_W  = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [3*WGT_W-1:0]   filtr_in,
  input  logic [IFMAP_W-1:0]   ifmap_shift_in,
  input  logic [PSUM_W-1:0]    psum_in,
  output logic [3*WGT_W-1:0]   filtr_out,
  output logic [IFMAP_W-1:0]   ifmap_shift_out,
  output logic [PSUM_W-1:0]    psum_out
);
  localparam int TAPS   = 3;
  localparam int PROD_W = IFMAP_W + WGT_W;

  logic [TAPS-1:0][IFMAP_W-1:0] r_tap;
  logic [TAPS-1:0][PROD_W-1:0]  r_prod;
  logic [TAPS-1:0][PROD_W-1:0]  w_prod;
  logic [PSUM_W-1:0]            r_psum;
  logic [3*WGT_W-1:0]           r_filtr;
  logic [PSUM_W-1:0]            w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tap   <= '0;
      r_filtr <= '0;
    end else if (en) begin
      r_tap   <= {r_tap[TAPS-2:0], ifmap_shift_in};
      r_filtr <= filtr_in;
    end
  end

  // Weights come straight from filtr_in, not the forwarded (delayed) copy.
  for (genvar k = 0; k < TAPS; k++) begin : g_mul
    assign w_prod[k] = PROD_W'(r_tap[k]) * PROD_W'(filtr_in[k*WGT_W +: WGT_W]);

    always_ff @(posedge clk) begin
      if (rst)     r_prod[k] <= '0;
      else if (en) r_prod[k] <= w_prod[k];
    end
  end

  // Products zero-extend into the psum width; the sum wraps modulo 2^PSUM_W.
  assign w_sum = psum_in + PSUM_W'(r_prod[0]) + PSUM_W'(r_prod[1]) + PSUM_W'(r_prod[2]);

  always_ff @(posedge clk) begin
    if (rst)     r_psum <= '0;
    else if (en) r_psum <= w_sum;
  end

  assign filtr_out       = r_filtr;
  assign ifmap_shift_out = r_tap[0];
  assign psum_out        = r_psum;
endmodule

// File: tb/tb_pe_conv_row_unit.sv
// Bench for pe_conv_row_unit: directed scenarios plus random traffic, all
// compared against a history-based model of the convolution.
module tb_pe_conv_row_unit;
  logic        clk = 1'b0;
  logic        rst, en;
  logic [11:0] filtr_in, filtr_out;
  logic [7:0]  ifmap_shift_in, ifmap_shift_out;
  logic [13:0] psum_in, psum_out;

  int n_chk = 0;
  int n_err = 0;

  pe_conv_row_unit dut (
    .clk(clk), .rst(rst), .en(en),
    .filtr_in(filtr_in), .ifmap_shift_in(ifmap_shift_in), .psum_in(psum_in),
    .filtr_out(filtr_out), .ifmap_shift_out(ifmap_shift_out), .psum_out(psum_out)
  );

  always #5 clk = ~clk;

  // Model: per accepted edge n, remember sample and weights. Output after edge n is
  // psum_in(n) + sum_K sample(n-2-K) * wK(n-1); history at or before a reset is zero.
  int          s_hist [0:4095];
  logic [11:0] w_hist [0:4095];
  int          n_edge = 0;
  int          floor_idx = 0;
  int          exp_psum = 0, exp_f = 0, exp_if = 0;

  function automatic int smp(input int i);
    if (i <= floor_idx) return 0;
    return s_hist[i];
  endfunction

  function automatic int wk(input logic [11:0] w, input int k);
    logic [11:0] t;
    t = w >> (4*k);
    return int'(t[3:0]);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic r, input logic e, input logic [11:0] w,
                      input logic [7:0] x, input logic [13:0] p);
    int acc;
    rst = r; en = e; filtr_in = w; ifmap_shift_in = x; psum_in = p;
    @(posedge clk);
    if (r) begin
      n_edge++;
      s_hist[n_edge] = 0; w_hist[n_edge] = '0; floor_idx = n_edge;
      exp_psum = 0; exp_f = 0; exp_if = 0;
    end else if (e) begin
      n_edge++;
      s_hist[n_edge] = int'(x); w_hist[n_edge] = w;
      acc = int'(p);
      for (int k = 0; k < 3; k++)
        acc += smp(n_edge-2-k) * wk(w_hist[n_edge-1], k);
      exp_psum = acc % 16384; exp_f = int'(w); exp_if = int'(x);
    end
    #1;
    chk("psum_out", int'(psum_out), exp_psum);
    chk("filtr_out", int'(filtr_out), exp_f);
    chk("ifmap_shift_out", int'(ifmap_shift_out), exp_if);
  endtask

  initial begin
    w_hist[0] = '0; s_hist[0] = 0;
    rst = 1'b1; en = 1'b1; filtr_in = '0; ifmap_shift_in = '0; psum_in = '0;
    @(negedge clk);

    // reset with garbage inputs and en high
    tick(1, 1, 12'hABC, 8'd77, 14'd999);
    tick(1, 1, 12'h5A5, 8'd200, 14'd12345);
    chk("reset_psum", int'(psum_out), 0);

    // steady state
    for (int i = 1; i <= 5; i++) begin
      tick(0, 1, 12'h321, 8'd10, 14'd5);
      if (i == 3) chk("steady_e3", int'(psum_out), 15);
      if (i == 4) chk("steady_e4", int'(psum_out), 35);
      if (i == 5) chk("steady_e5", int'(psum_out), 65);
    end

    // enable hold
    for (int i = 0; i < 3; i++) tick(0, 0, 12'hFFF, 8'd99, 14'd0);
    chk("hold_psum", int'(psum_out), 65);
    chk("hold_filtr", int'(filtr_out), 12'h321);

    // reset mid-stream: earlier products must not reappear
    tick(1, 1, 12'h321, 8'd10, 14'd5);
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 12'h321, 8'd0, 14'd0);
      chk("post_reset_zero", int'(psum_out), 0);
    end

    // pipeline order
    begin
      logic [7:0] seq [0:5];
      seq = '{8'd10, 8'd20, 8'd30, 8'd0, 8'd0, 8'd0};
      for (int i = 0; i < 6; i++) tick(0, 1, 12'h321, seq[i], 14'd0);
    end

    // overflow wrap
    for (int i = 0; i < 5; i++) tick(0, 1, 12'hFFF, 8'd255, 14'd16383);
    chk("wrap", int'(psum_out), 11474);

    // random traffic
    for (int i = 0; i < 400; i++)
      tick(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 80),
           12'($urandom), 8'($urandom), 14'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
